// File: rtl/line_rasterizer.sv
// line_rasterizer: Bresenham line engine writing (x, y, address, colour)
// pixel beats into the frame buffer over a valid/ready stream. Handles all
// eight octants and silently skips candidates outside the frame buffer.
module line_rasterizer #(
    parameter int FB_WIDTH  = 1280,
    parameter int FB_HEIGHT = 720,
    parameter int ADDR_W    = $clog2(FB_WIDTH * FB_HEIGHT)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [10:0]       x1_in,
    input  logic [9:0]        y1_in,
    input  logic [10:0]       x2_in,
    input  logic [9:0]        y2_in,
    input  logic [23:0]       color_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              pixel_valid_out,
    input  logic              pixel_ready_in,
    output logic [10:0]       pixel_x_out,
    output logic [9:0]        pixel_y_out,
    output logic [ADDR_W-1:0] pixel_addr_out,
    output logic [23:0]       pixel_color_out,
    output logic              pixel_last_out
);

    // DRAIN waits for the consumer to take the final in-bounds beat.
    typedef enum logic [1:0] {IDLE, SETUP, STEP, DRAIN} state_t;

    localparam logic [11:0] FB_W_X = 12'(FB_WIDTH);
    localparam logic [10:0] FB_H_Y = 11'(FB_HEIGHT);

    state_t state, state_nxt;

    logic [10:0] x1_q, x2_q;
    logic [9:0]  y1_q, y2_q;
    logic [23:0] color_q;

    logic signed [13:0] err_q;
    logic [11:0]        x_q;
    logic [10:0]        y_q;

    // Line constants derive from the latched endpoints, so they need no
    // registers of their own and are already valid during SETUP.
    logic [10:0]        adx;
    logic [9:0]         ady;
    logic signed [13:0] dx_c, dy_c;
    logic               sx_neg, sy_neg;

    logic signed [13:0] cur_err, e2, nxt_err;
    logic [11:0]        cur_x, nxt_x;
    logic [10:0]        cur_y, nxt_y;
    logic               step_x, step_y;
    logic               in_bounds, at_end, advance, done_nxt;
    logic [ADDR_W-1:0]  addr_c;

    assign busy_out = (state != IDLE);

    // Stepper datapath: SETUP steps the first point (x1, y1) with the initial
    // error term so the first beat appears one cycle after SETUP.
    always_comb begin
        adx     = (x2_q >= x1_q) ? (x2_q - x1_q) : (x1_q - x2_q);
        ady     = (y2_q >= y1_q) ? (y2_q - y1_q) : (y1_q - y2_q);
        dx_c    = $signed({3'b000, adx});
        dy_c    = -$signed({4'b0000, ady});
        sx_neg  = !(x1_q < x2_q);
        sy_neg  = !(y1_q < y2_q);

        cur_err = err_q;
        cur_x   = x_q;
        cur_y   = y_q;
        if (state == SETUP) begin
            cur_err = dx_c + dy_c;
            cur_x   = {1'b0, x1_q};
            cur_y   = {1'b0, y1_q};
        end

        e2      = {cur_err[12:0], 1'b0};
        step_x  = (e2 >= dy_c);
        step_y  = (e2 <= dx_c);
        nxt_err = cur_err + (step_x ? dy_c : 14'sd0) + (step_y ? dx_c : 14'sd0);
        nxt_x   = step_x ? (sx_neg ? cur_x - 12'd1 : cur_x + 12'd1) : cur_x;
        nxt_y   = step_y ? (sy_neg ? cur_y - 11'd1 : cur_y + 11'd1) : cur_y;

        in_bounds = (cur_x < FB_W_X) && (cur_y < FB_H_Y);
        at_end    = (cur_x == {1'b0, x2_q}) && (cur_y == {1'b0, y2_q});
        advance   = (state == SETUP) ||
                    ((state == STEP) && (!pixel_valid_out || pixel_ready_in));
        addr_c    = ADDR_W'(cur_y[9:0] * FB_WIDTH) + ADDR_W'(cur_x[10:0]);
    end

    // Next-state and done decision.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE:  if (start_in) state_nxt = SETUP;
            SETUP, STEP: begin
                if (advance && at_end) begin
                    if (in_bounds) begin
                        state_nxt = DRAIN;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else if (state == SETUP) begin
                    state_nxt = STEP;
                end
            end
            DRAIN: begin
                if (pixel_ready_in) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    // Request latch, stepper registers and the pixel output register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            x1_q            <= '0;
            x2_q            <= '0;
            y1_q            <= '0;
            y2_q            <= '0;
            color_q         <= '0;
            err_q           <= '0;
            x_q             <= '0;
            y_q             <= '0;
            done_out        <= 1'b0;
            pixel_valid_out <= 1'b0;
            pixel_x_out     <= '0;
            pixel_y_out     <= '0;
            pixel_addr_out  <= '0;
            pixel_color_out <= '0;
            pixel_last_out  <= 1'b0;
        end else begin
            done_out <= done_nxt;
            if (state == IDLE && start_in) begin
                x1_q    <= x1_in;
                y1_q    <= y1_in;
                x2_q    <= x2_in;
                y2_q    <= y2_in;
                color_q <= color_in;
            end
            if (advance) begin
                err_q           <= nxt_err;
                x_q             <= nxt_x;
                y_q             <= nxt_y;
                pixel_valid_out <= in_bounds;
                if (in_bounds) begin
                    pixel_x_out     <= cur_x[10:0];
                    pixel_y_out     <= cur_y[9:0];
                    pixel_addr_out  <= addr_c;
                    pixel_color_out <= color_q;
                    pixel_last_out  <= at_end;
                end
            end else if (state == DRAIN && pixel_ready_in) begin
                pixel_valid_out <= 1'b0;
                pixel_last_out  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_line_rasterizer.sv
// Self-checking bench for line_rasterizer: directed lines from the test plan
// plus randomized lines near the frame buffer edges, compared beat by beat
// against a queue of expected pixels built from integer Bresenham arithmetic.
module tb_line_rasterizer;

    localparam int W = 1280;
    localparam int H = 720;
    localparam int AW = $clog2(W * H);

    logic          clk = 0;
    logic          rst = 1;
    logic          start = 0;
    logic [10:0]   x1 = 0, x2 = 0;
    logic [9:0]    y1 = 0, y2 = 0;
    logic [23:0]   color = 0;
    logic          busy, done, valid, last;
    logic          ready = 0;
    logic [10:0]   px;
    logic [9:0]    py;
    logic [AW-1:0] paddr;
    logic [23:0]   pcolor;

    line_rasterizer #(.FB_WIDTH(W), .FB_HEIGHT(H)) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start),
        .x1_in(x1), .y1_in(y1), .x2_in(x2), .y2_in(y2), .color_in(color),
        .busy_out(busy), .done_out(done),
        .pixel_valid_out(valid), .pixel_ready_in(ready),
        .pixel_x_out(px), .pixel_y_out(py), .pixel_addr_out(paddr),
        .pixel_color_out(pcolor), .pixel_last_out(last)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; bit last; } beat_t;
    beat_t exp_q[$];
    int    n_pts;
    bit    first_in, end_in;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Every point of the ideal line from (ax,ay) to (bx,by); only on-screen
    // points become expected beats.
    task automatic build_model(input int ax, input int ay, input int bx, input int by);
        int dx, dy, sx, sy, err, e2, x, y;
        beat_t b;
        exp_q.delete();
        dx  = (bx > ax) ? bx - ax : ax - bx;
        dy  = -((by > ay) ? by - ay : ay - by);
        sx  = (ax < bx) ? 1 : -1;
        sy  = (ay < by) ? 1 : -1;
        err = dx + dy;
        x = ax; y = ay;
        n_pts = 0;
        first_in = (ax < W) && (ay < H);
        end_in   = (bx < W) && (by < H);
        forever begin
            n_pts++;
            if (x < W && y < H) begin
                b.x = x; b.y = y; b.last = (x == bx && y == by);
                exp_q.push_back(b);
            end
            if (x == bx && y == by) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    // Called at a falling edge. mode 0: ready always high, 1: random ready,
    // 2: ready low for three cycles once two beats have been taken.
    // inj_k >= 0 pulses a conflicting start request at that loop cycle.
    task automatic run_line(input int ax, input int ay, input int bx, input int by,
                            input logic [23:0] c, input int mode, input int inj_k);
        int  acc, last_acc, hold, n_in;
        bit  r, got_done;
        build_model(ax, ay, bx, by);
        n_in = exp_q.size();
        acc = 0; last_acc = -10; hold = 0; got_done = 0;
        x1 = 11'(ax); y1 = 10'(ay); x2 = 11'(bx); y2 = 10'(by); color = c;
        start = 1;
        @(negedge clk);
        start = 0;
        chk("setup_busy", 32'(busy), 1);
        chk("setup_valid", 32'(valid), 0);
        chk("setup_done", 32'(done), 0);
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            start = 0;
            if (k == inj_k) begin
                x1 = 11'd500; y1 = 10'd300; x2 = 11'd20; y2 = 10'd100; start = 1;
            end
            case (mode)
                0: r = 1;
                1: r = ($urandom_range(0, 3) != 0);
                default: begin
                    r = 1;
                    if (acc == 2 && hold < 3) begin r = 0; hold++; end
                end
            endcase
            ready = r;
            if (k == 0) chk("first_valid", 32'(valid), 32'(first_in));
            if (done) begin
                got_done = 1;
                chk("done_all_beats", 32'(acc), 32'(n_in));
                chk("done_busy_low", 32'(busy), 0);
                chk("done_valid_low", 32'(valid), 0);
                if (mode == 0)
                    chk("done_cycle", 32'(k), 32'(end_in ? n_pts : n_pts - 1));
                else if (end_in)
                    chk("done_after_last", 32'(k), 32'(last_acc + 1));
                break;
            end
            if (valid) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 32'(acc + 1), 32'(n_in));
                end else begin
                    chk("beat_x", 32'(px), 32'(exp_q[0].x));
                    chk("beat_y", 32'(py), 32'(exp_q[0].y));
                    chk("beat_addr", 32'(paddr), 32'(exp_q[0].y * W + exp_q[0].x));
                    chk("beat_color", 32'(pcolor), 32'(c));
                    chk("beat_last", 32'(last), 32'(exp_q[0].last));
                    if (r) begin
                        void'(exp_q.pop_front());
                        acc++;
                        last_acc = k;
                    end
                end
            end
        end
        start = 0;
        if (!got_done) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int ax, ay, bx, by;
        rst = 1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_last", 32'(last), 0);
        chk("rst_x", 32'(px), 0);
        chk("rst_y", 32'(py), 0);
        chk("rst_addr", 32'(paddr), 0);
        chk("rst_color", 32'(pcolor), 0);
        rst = 0;
        @(negedge clk);

        // Directed lines; consecutive calls start in the done cycle.
        run_line(10, 5, 13, 5, 24'h123456, 0, -1);
        run_line(3, 7, 1, 2, 24'h00FF00, 0, -1);
        run_line(0, 0, 5, 5, 24'hABCDEF, 2, -1);
        run_line(0, 0, 0, 0, 24'hFF0000, 0, -1);
        run_line(1278, 0, 1281, 0, 24'h0000FF, 0, -1);
        run_line(2, 3, 40, 17, 24'h777777, 0, 2);
        run_line(100, 50, 60, 90, 24'h010203, 1, 4);

        // Reset while the third beat of a ten-pixel line is presented.
        ready = 1;
        x1 = 0; y1 = 0; x2 = 9; y2 = 0; color = 24'h55AA55; start = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        chk("pre_rst_beat3_x", 32'(px), 2);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midrst_valid", 32'(valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(done), 0);
        end
        run_line(7, 9, 1, 12, 24'hC0FFEE, 0, -1);

        // Random lines clustered around the frame buffer edges.
        for (int i = 0; i < 40; i++) begin
            ax = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 60) : $urandom_range(1240, 1320);
            bx = ($urandom_range(0, 1) != 0) ? ax + $urandom_range(0, 50) : ax - $urandom_range(0, ax < 50 ? ax : 50);
            ay = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 40) : $urandom_range(690, 760);
            by = ($urandom_range(0, 1) != 0) ? ay + $urandom_range(0, 40) : ay - $urandom_range(0, ay < 40 ? ay : 40);
            run_line(ax, ay, bx, by, 24'($urandom), $urandom_range(0, 1), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
